arbitro_entrada_salida: RTL and testbench
=========================================

Name: arbitro_entrada_salida

Overview:
- Shares the single processor I/O port bus between two requesters: master 0 is the CPU datapath and master 1 is the auxiliary/DMA engine.
- Drives the I/O block's activarEntradaSalida, escribirEntradaSalida, direccionEntradaSalida and entradaEntradaSalida signals, and captures salidaEntradaSalida.
- Round-robin arbitration, one transaction in flight at a time, request/done handshake per master.

Parameters:
- ANCHO_DATO, 8, data width of the I/O port.
- ANCHO_DIR, 7, address width of the I/O port.
- MAX_DIR, 4, highest implemented device address (devices 0..4).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- peticion0 / peticion1  in  1  transaction request, level, held until hecho.
- escribir0 / escribir1  in  1  1 = write, 0 = read.
- direccion0 / direccion1  in  ANCHO_DIR  target device address.
- datoEscritura0 / datoEscritura1  in  ANCHO_DATO  write data.
- hecho0 / hecho1  out  1  one-cycle completion pulse.
- datoLeido0 / datoLeido1  out  ANCHO_DATO  read result, valid with hecho, held until the next read by that master.
- errorDir0 / errorDir1  out  1  pulses with hecho when the address exceeds MAX_DIR.
- activarEntradaSalida  out  1  I/O bus enable.
- escribirEntradaSalida  out  1  I/O bus write strobe qualifier.
- direccionEntradaSalida  out  ANCHO_DIR  I/O bus address.
- entradaEntradaSalida  out  ANCHO_DATO  data to the I/O block.
- salidaEntradaSalida  in  ANCHO_DATO  read data from the I/O block.

Behaviour:
- **Reset** (reset=0, asynchronous):
  - state = REPOSO; all outputs 0; datoLeido0/1 = 0.
  - ultimo = 1, so master 0 wins the first tie.
  - An in-flight transaction is dropped: activar falls immediately and no hecho is produced.
- **REPOSO:**
  - A master is eligible if peticionN=1 and hechoN=0 in the same cycle. This masks a master that is still dropping its request.
  - One eligible master: grant it.
  - Both eligible: grant the master != ultimo.
  - On grant, register owner, escribir, direccion and dato from the winner, then go to ACCESO.
  - No eligible master: stay in REPOSO; bus outputs are 0.
- **ACCESO** (exactly 1 cycle):
  - Bus outputs are registered from the latched command.
  - activarEntradaSalida = 1 unless direccion > MAX_DIR, in which case activar = 0 (access suppressed).
  - Write: the next state is REPOSO, and hecho[owner] = 1 in the following cycle.
  - Read: the next state is CAPTURA.
- **CAPTURA** (1 cycle):
  - activar = 0; address is held.
  - At the end of the cycle, datoLeido[owner] <= salidaEntradaSalida, or 8'h00 if the address is out of range.
  - hecho[owner] pulses in the next cycle; the next state is REPOSO.
- **Completion** (both directions): ultimo <= owner; errorDir[owner] = hecho[owner] AND out-of-range.
- **Latency**, counted from the cycle REPOSO samples the request (cycle 0):
  - activar is high in cycle 1.
  - Write: hecho in cycle 2.
  - Read: hecho and datoLeido in cycle 3.
- **Input stability:** changes on a master's inputs after the grant are ignored because the command is latched.
- **Throughput:** a new grant can occur in the same cycle hecho is high, for the other master only.
- **Fairness:** with both masters requesting continuously, grants alternate 0,1,0,1…
- **Width:** direccion is compared unsigned against MAX_DIR at full ANCHO_DIR width; no truncation.

Decomposition:
- Shared package holds:
  - state encoding: REPOSO = 2'b00, ACCESO = 2'b01, CAPTURA = 2'b10;
  - ANCHO_DATO, ANCHO_DIR and MAX_DIR defaults;
  - the master-index type (1 bit).
- One sub-module, arbitro_rr_2:
  - inputs: the two eligible bits and ultimo;
  - outputs: hay_ganador and ganador;
  - purely combinational.
- The top module holds the FSM, command registers and ultimo.

Test Plan:
- Reset release, master 0 writes 8'hA5 to direccion 2 -> activar=1, escribir=1, dir=2, entrada=8'hA5 in cycle 1; hecho0 in cycle 2; errorDir0=0.
- Master 1 reads direccion 2 with salidaEntradaSalida=8'h3C -> activar=1, escribir=0 in cycle 1; datoLeido1=8'h3C with hecho1 in cycle 3.
- Both masters request writes in the same cycle after reset -> grants in order 0,1,0,1 over four transactions; bus never carries two commands at once.
- Master 0 reads direccion 7'd9 -> activar stays 0 throughout; hecho0 and errorDir0 pulse together in cycle 3; datoLeido0=8'h00.
- Reset asserted during ACCESO of a write -> activar drops asynchronously; no hecho; after release, the first tie is granted to master 0.
- Master 0 changes direccion and datoEscritura during ACCESO -> the bus keeps the originally latched values.

Source files
------------

// File: rtl/arbitro_entrada_salida_pkg.sv
// Shared definitions for the two-master I/O port arbiter: default widths,
// FSM state encoding and the master-index type.
package arbitro_entrada_salida_pkg;

  localparam int ANCHO_DATO_DEF = 8;
  localparam int ANCHO_DIR_DEF  = 7;
  localparam int MAX_DIR_DEF    = 4;

  localparam logic [1:0] REPOSO  = 2'b00;
  localparam logic [1:0] ACCESO  = 2'b01;
  localparam logic [1:0] CAPTURA = 2'b10;

  // Master 0 is the CPU datapath, master 1 the auxiliary/DMA engine.
  typedef logic maestro_t;

endpackage

// File: rtl/arbitro_rr_2.sv
// Two-way round-robin pick: on a tie the master that did not complete last wins.
module arbitro_rr_2
  import arbitro_entrada_salida_pkg::*;
(
  input  logic [1:0] elegible,
  input  maestro_t   ultimo,
  output logic       hay_ganador,
  output maestro_t   ganador
);

  assign hay_ganador = |elegible;
  assign ganador     = (&elegible) ? maestro_t'(~ultimo) : maestro_t'(elegible[1]);

endmodule

// File: rtl/arbitro_entrada_salida.sv
// Shares the processor I/O port between the CPU datapath and the DMA engine:
// round-robin grant, one transaction in flight, request/done handshake per master.
module arbitro_entrada_salida
  import arbitro_entrada_salida_pkg::*;
#(
  parameter int ANCHO_DATO = ANCHO_DATO_DEF,
  parameter int ANCHO_DIR  = ANCHO_DIR_DEF,
  parameter int MAX_DIR    = MAX_DIR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  peticion0,
  input  logic                  peticion1,
  input  logic                  escribir0,
  input  logic                  escribir1,
  input  logic [ANCHO_DIR-1:0]  direccion0,
  input  logic [ANCHO_DIR-1:0]  direccion1,
  input  logic [ANCHO_DATO-1:0] datoEscritura0,
  input  logic [ANCHO_DATO-1:0] datoEscritura1,
  output logic                  hecho0,
  output logic                  hecho1,
  output logic [ANCHO_DATO-1:0] datoLeido0,
  output logic [ANCHO_DATO-1:0] datoLeido1,
  output logic                  errorDir0,
  output logic                  errorDir1,
  output logic                  activarEntradaSalida,
  output logic                  escribirEntradaSalida,
  output logic [ANCHO_DIR-1:0]  direccionEntradaSalida,
  output logic [ANCHO_DATO-1:0] entradaEntradaSalida,
  input  logic [ANCHO_DATO-1:0] salidaEntradaSalida
);

  localparam logic [31:0] MAX_DIR_U = 32'(MAX_DIR);

  logic [1:0]            estado;
  maestro_t              owner;
  maestro_t              ultimo;
  logic                  cmd_fuera;
  logic                  cmd_activar;
  logic                  cmd_escribir;
  logic [ANCHO_DIR-1:0]  cmd_dir;
  logic [ANCHO_DATO-1:0] cmd_dato;
  logic [1:0]            hecho_q;
  logic [1:0]            error_q;
  logic [ANCHO_DATO-1:0] dato_leido0_q;
  logic [ANCHO_DATO-1:0] dato_leido1_q;

  logic [1:0]            elegible;
  logic                  hay_ganador;
  maestro_t              ganador;
  logic                  esc_sel;
  logic [ANCHO_DIR-1:0]  dir_sel;
  logic [ANCHO_DATO-1:0] dato_sel;
  logic                  fuera_sel;
  logic [ANCHO_DATO-1:0] dato_cap;

  // A master whose done pulse is still high is dropping its request; mask it.
  assign elegible = {peticion1 & ~hecho_q[1], peticion0 & ~hecho_q[0]};

  arbitro_rr_2 u_rr (
    .elegible    (elegible),
    .ultimo      (ultimo),
    .hay_ganador (hay_ganador),
    .ganador     (ganador)
  );

  assign esc_sel   = ganador ? escribir1      : escribir0;
  assign dir_sel   = ganador ? direccion1     : direccion0;
  assign dato_sel  = ganador ? datoEscritura1 : datoEscritura0;
  // Full-width unsigned compare so high address bits are never truncated away.
  assign fuera_sel = 32'(dir_sel) > MAX_DIR_U;
  assign dato_cap  = cmd_fuera ? '0 : salidaEntradaSalida;

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // the async reset also kills an in-flight access without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado        <= REPOSO;
      owner         <= 1'b0;
      ultimo        <= 1'b1;
      cmd_fuera     <= 1'b0;
      cmd_activar   <= 1'b0;
      cmd_escribir  <= 1'b0;
      cmd_dir       <= '0;
      cmd_dato      <= '0;
      hecho_q       <= '0;
      error_q       <= '0;
      dato_leido0_q <= '0;
      dato_leido1_q <= '0;
    end else begin
      hecho_q <= '0;
      error_q <= '0;
      case (estado)
        REPOSO: begin
          if (hay_ganador) begin
            owner        <= ganador;
            cmd_fuera    <= fuera_sel;
            cmd_activar  <= ~fuera_sel;
            cmd_escribir <= esc_sel;
            cmd_dir      <= dir_sel;
            cmd_dato     <= dato_sel;
            estado       <= ACCESO;
          end else begin
            cmd_activar  <= 1'b0;
            cmd_escribir <= 1'b0;
            cmd_dir      <= '0;
            cmd_dato     <= '0;
          end
        end
        ACCESO: begin
          cmd_activar <= 1'b0;
          if (cmd_escribir) begin
            cmd_escribir   <= 1'b0;
            cmd_dir        <= '0;
            cmd_dato       <= '0;
            hecho_q[owner] <= 1'b1;
            error_q[owner] <= cmd_fuera;
            ultimo         <= owner;
            estado         <= REPOSO;
          end else begin
            estado <= CAPTURA;
          end
        end
        CAPTURA: begin
          if (owner) dato_leido1_q <= dato_cap;
          else       dato_leido0_q <= dato_cap;
          cmd_escribir   <= 1'b0;
          cmd_dir        <= '0;
          cmd_dato       <= '0;
          hecho_q[owner] <= 1'b1;
          error_q[owner] <= cmd_fuera;
          ultimo         <= owner;
          estado         <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

  assign hecho0                 = hecho_q[0];
  assign hecho1                 = hecho_q[1];
  assign errorDir0              = error_q[0];
  assign errorDir1              = error_q[1];
  assign datoLeido0             = dato_leido0_q;
  assign datoLeido1             = dato_leido1_q;
  assign activarEntradaSalida   = cmd_activar;
  assign escribirEntradaSalida  = cmd_escribir;
  assign direccionEntradaSalida = cmd_dir;
  assign entradaEntradaSalida   = cmd_dato;

endmodule

// File: tb/tb_arbitro_entrada_salida.sv
// Directed bench for arbitro_entrada_salida: handshake latency, round-robin
// order, out-of-range addresses, asynchronous reset and command latching.
module tb_arbitro_entrada_salida;

  logic       clk = 1'b0;
  logic       reset;
  logic       peticion0, peticion1, escribir0, escribir1;
  logic [6:0] direccion0, direccion1;
  logic [7:0] datoEscritura0, datoEscritura1;
  logic       hecho0, hecho1, errorDir0, errorDir1;
  logic [7:0] datoLeido0, datoLeido1;
  logic       activarEntradaSalida, escribirEntradaSalida;
  logic [6:0] direccionEntradaSalida;
  logic [7:0] entradaEntradaSalida, salidaEntradaSalida;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  arbitro_entrada_salida dut (
    .clk                    (clk),
    .reset                  (reset),
    .peticion0              (peticion0),
    .peticion1              (peticion1),
    .escribir0              (escribir0),
    .escribir1              (escribir1),
    .direccion0             (direccion0),
    .direccion1             (direccion1),
    .datoEscritura0         (datoEscritura0),
    .datoEscritura1         (datoEscritura1),
    .hecho0                 (hecho0),
    .hecho1                 (hecho1),
    .datoLeido0             (datoLeido0),
    .datoLeido1             (datoLeido1),
    .errorDir0              (errorDir0),
    .errorDir1              (errorDir1),
    .activarEntradaSalida   (activarEntradaSalida),
    .escribirEntradaSalida  (escribirEntradaSalida),
    .direccionEntradaSalida (direccionEntradaSalida),
    .entradaEntradaSalida   (entradaEntradaSalida),
    .salidaEntradaSalida    (salidaEntradaSalida)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pedir(input int m, input logic esc, input logic [6:0] dir, input logic [7:0] dato);
    if (m == 0) begin
      peticion0 = 1'b1; escribir0 = esc; direccion0 = dir; datoEscritura0 = dato;
    end else begin
      peticion1 = 1'b1; escribir1 = esc; direccion1 = dir; datoEscritura1 = dato;
    end
  endtask

  task automatic idle();
    peticion0 = 1'b0;
    peticion1 = 1'b0;
    tick();
  endtask

  logic [6:0] grant_dir [4];
  int         n_grant;
  int         n_done0, n_done1;

  initial begin
    reset = 1'b0;
    peticion0 = 0; peticion1 = 0; escribir0 = 0; escribir1 = 0;
    direccion0 = 0; direccion1 = 0; datoEscritura0 = 0; datoEscritura1 = 0;
    salidaEntradaSalida = 8'h00;
    tick(); tick();
    check("rst_activar", activarEntradaSalida, 0);
    check("rst_hecho", {hecho1, hecho0}, 0);
    check("rst_dato", {datoLeido1, datoLeido0}, 0);
    reset = 1'b1;
    tick();

    // Master 0 write 8'hA5 to device 2
    pedir(0, 1'b1, 7'd2, 8'hA5);
    tick();
    check("wr_c1_bus", {activarEntradaSalida, escribirEntradaSalida, direccionEntradaSalida, entradaEntradaSalida},
          {1'b1, 1'b1, 7'd2, 8'hA5});
    check("wr_c1_hecho", hecho0, 0);
    tick();
    check("wr_c2_hecho", {hecho0, errorDir0, activarEntradaSalida}, 3'b100);
    idle();
    check("wr_c3_hecho", hecho0, 0);

    // Master 1 read device 2
    salidaEntradaSalida = 8'h3C;
    pedir(1, 1'b0, 7'd2, 8'h00);
    tick();
    check("rd_c1_bus", {activarEntradaSalida, escribirEntradaSalida, direccionEntradaSalida}, {1'b1, 1'b0, 7'd2});
    tick();
    check("rd_c2", {activarEntradaSalida, hecho1, direccionEntradaSalida}, {1'b0, 1'b0, 7'd2});
    tick();
    check("rd_c3_hecho", {hecho1, errorDir1}, 2'b10);
    check("rd_c3_dato", datoLeido1, 8'h3C);
    idle();

    // Fairness: both write, two transactions each, right after reset
    reset = 1'b0;
    #4;
    reset = 1'b1;
    pedir(0, 1'b1, 7'd1, 8'h11);
    pedir(1, 1'b1, 7'd3, 8'h22);
    n_grant = 0; n_done0 = 0; n_done1 = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (hecho0 && hecho1) check("rr_doble_hecho", {hecho1, hecho0}, 2'b01);
      if (activarEntradaSalida) begin
        if (n_grant < 4) grant_dir[n_grant] = direccionEntradaSalida;
        n_grant++;
      end
      if (hecho0) begin n_done0++; if (n_done0 == 2) peticion0 = 1'b0; end
      if (hecho1) begin n_done1++; if (n_done1 == 2) peticion1 = 1'b0; end
      if (n_done0 == 2 && n_done1 == 2) break;
    end
    check("rr_n_grant", n_grant, 4);
    check("rr_g0", grant_dir[0], 7'd1);
    check("rr_g1", grant_dir[1], 7'd3);
    check("rr_g2", grant_dir[2], 7'd1);
    check("rr_g3", grant_dir[3], 7'd3);
    idle();

    // Boundary: MAX_DIR itself is in range
    salidaEntradaSalida = 8'h5A;
    pedir(0, 1'b0, 7'd4, 8'h00);
    tick();
    check("max_c1_activar", activarEntradaSalida, 1);
    tick(); tick();
    check("max_c3", {hecho0, errorDir0, datoLeido0}, {1'b1, 1'b0, 8'h5A});
    idle();

    // Master 0 read out of range
    salidaEntradaSalida = 8'hFF;
    pedir(0, 1'b0, 7'd9, 8'h00);
    tick();
    check("oor_c1_activar", activarEntradaSalida, 0);
    tick();
    check("oor_c2_activar", activarEntradaSalida, 0);
    tick();
    check("oor_c3", {activarEntradaSalida, hecho0, errorDir0, datoLeido0}, {1'b0, 1'b1, 1'b1, 8'h00});
    idle();

    // Master 1 write to MAX_DIR+1
    pedir(1, 1'b1, 7'd5, 8'h66);
    tick();
    check("oorw_c1_activar", activarEntradaSalida, 0);
    tick();
    check("oorw_c2", {hecho1, errorDir1}, 2'b11);
    idle();

    // Reset during ACCESO of a write
    pedir(0, 1'b1, 7'd0, 8'h77);
    tick();
    check("rstacc_c1_activar", activarEntradaSalida, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rstacc_async_drop", activarEntradaSalida, 0);
    pedir(0, 1'b1, 7'd1, 8'h01);
    pedir(1, 1'b1, 7'd3, 8'h03);
    tick();
    check("rstacc_no_hecho", {hecho1, hecho0, activarEntradaSalida}, 0);
    reset = 1'b1;
    tick();
    check("rstacc_tie_m0", {activarEntradaSalida, direccionEntradaSalida}, {1'b1, 7'd1});
    peticion1 = 1'b0;
    tick();
    check("rstacc_hecho0", {hecho1, hecho0}, 2'b01);
    idle();

    // Command latched: changing inputs during ACCESO has no effect
    salidaEntradaSalida = 8'h42;
    pedir(0, 1'b0, 7'd1, 8'h00);
    tick();
    check("lat_c1", {activarEntradaSalida, escribirEntradaSalida, direccionEntradaSalida}, {1'b1, 1'b0, 7'd1});
    escribir0 = 1'b1; direccion0 = 7'd3; datoEscritura0 = 8'hFF;
    tick();
    check("lat_c2", {escribirEntradaSalida, direccionEntradaSalida, entradaEntradaSalida}, {1'b0, 7'd1, 8'h00});
    tick();
    check("lat_c3", {hecho0, datoLeido0}, {1'b1, 8'h42});
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
